// File: rtl/baud_tick_gen.sv
// Programmable oversample / mid-bit / bit tick generator for the UART datapaths.
// Define BAUD_FRAC_EN to build the fractional accumulator; otherwise frac is ignored.
`timescale 1ns/1ps

module baud_tick_gen #(
  parameter int DIV_W  = 16,
  parameter int OSR    = 16,
  parameter int FRAC_W = 4
) (
  input  logic                    CLK288MHZ,
  input  logic                    reset,
  input  logic                    baudReset,
  input  logic                    enable,
  input  logic [DIV_W-1:0]        divisor,
  input  logic [FRAC_W-1:0]       frac,
  output logic                    os_tick,
  output logic [$clog2(OSR)-1:0]  os_index,
  output logic                    mid_tick,
  output logic                    bit_tick,
  output logic                    cfg_err
);

  localparam int IDX_W = $clog2(OSR);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OSR - 1);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OSR / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [DIV_W:0]   EFF_ONE  = (DIV_W + 1)'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             os_tick_q, os_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             carry;
  logic [DIV_W:0]   eff;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;

  // The bit shifted out of the accumulator stretches this period by one cycle.
  assign acc_sum = {1'b0, acc_q} + {1'b0, frac};
  assign carry   = acc_sum[FRAC_W];
`else
  logic unused_frac;

  assign unused_frac = ^frac;
  assign carry       = 1'b0;
`endif

  // A zero divisor is treated as one so the generator never stalls.
  assign eff = ((divisor == '0) ? EFF_ONE : {1'b0, divisor})
             + {{DIV_W{1'b0}}, carry};

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    cfg_err_d  = cfg_err_q;
`ifdef BAUD_FRAC_EN
    acc_d      = acc_q;
`endif
    if (baudReset) begin
      cnt_d     = '0;
      idx_d     = IDX_LAST;
      cfg_err_d = 1'b0;
`ifdef BAUD_FRAC_EN
      acc_d     = '0;
`endif
    end else if (enable) begin
      if (cnt_q == '0) begin
        cnt_d      = DIV_W'(eff - EFF_ONE);
        idx_d      = idx_q + IDX_ONE;
        os_tick_d  = 1'b1;
        mid_tick_d = (idx_d == IDX_MID);
        bit_tick_d = (idx_d == IDX_LAST);
        cfg_err_d  = (divisor == '0);
`ifdef BAUD_FRAC_EN
        acc_d      = acc_sum[FRAC_W-1:0];
`endif
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK288MHZ or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= IDX_LAST;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef BAUD_FRAC_EN
      acc_q      <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
      cfg_err_q  <= cfg_err_d;
`ifdef BAUD_FRAC_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign os_tick  = os_tick_q;
  assign os_index = idx_q;
  assign mid_tick = mid_tick_q;
  assign bit_tick = bit_tick_q;
  assign cfg_err  = cfg_err_q;

endmodule
